// File: rtl/add_transition_pipe.sv
// ---------------------------------------------------------------------------
// add_transition_pipe
//   Two-stage add/subtract unit on a valid/ready stream. Stage 1 forms the
//   WIDTH-bit result and carry/borrow. Stage 2 registers the result together
//   with the number of adjacent-bit transitions in it. Saturating statistics
//   (total transitions, delivered results, sticky saturation flag) are kept
//   for software readout and are updated only when a result is delivered.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/ready    operand handshake; in_ready is combinational
//   in_a, in_b        unsigned operands
//   in_sub            0: a+b, 1: a-b
//   out_valid/ready   result handshake
//   out_sum           result modulo 2**WIDTH
//   out_cy            add: carry out, sub: borrow (a<b)
//   out_trans         count of i in [0,WIDTH-2] with sum[i]^sum[i+1]
//   stat_clr          synchronous statistics clear
//   stat_trans        saturating sum of delivered out_trans
//   stat_count        saturating count of delivered results
//   stat_sat          sticky: an accumulator clamped
// ---------------------------------------------------------------------------
module add_transition_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH),
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cy,
    output logic [CNT_W-1:0] out_trans,
    input  logic             stat_clr,
    output logic [ACC_W-1:0] stat_trans,
    output logic [ACC_W-1:0] stat_count,
    output logic             stat_sat
);

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    // ---------------- pipeline state ----------------
    logic             s1_valid_q, s2_valid_q;
    logic [WIDTH-1:0] s1_sum_q, s2_sum_q;
    logic             s1_cy_q, s2_cy_q;
    logic [CNT_W-1:0] s2_trans_q;

    logic             s1_adv, s2_adv;
    logic             in_xfer, out_xfer;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign in_xfer  = in_valid && s1_adv;
    assign out_xfer = s2_valid_q && out_ready;

    // ---------------- stage 1 arithmetic ----------------
    // Subtraction is a + ~b + 1; the carry out of that is "no borrow",
    // so it is inverted to report the borrow.
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic             cy_eff;

    always_comb begin
        b_eff   = in_sub ? ~in_b : in_b;
        sum_ext = {1'b0, in_a} + {1'b0, b_eff} + (WIDTH+1)'(in_sub);
        cy_eff  = in_sub ? ~sum_ext[WIDTH] : sum_ext[WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_cy_q    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            // Data regs only move on a real beat to avoid spurious toggles.
            if (in_valid) begin
                s1_sum_q <= sum_ext[WIDTH-1:0];
                s1_cy_q  <= cy_eff;
            end
        end
    end

    // ---------------- stage 2 transition count ----------------
    logic [WIDTH-2:0] tvec;
    logic [CNT_W-1:0] tcnt;

    always_comb begin
        tvec = s1_sum_q[WIDTH-1:1] ^ s1_sum_q[WIDTH-2:0];
        tcnt = '0;
        for (int i = 0; i < WIDTH-1; i++) begin
            tcnt = tcnt + CNT_W'(tvec[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_cy_q    <= 1'b0;
            s2_trans_q <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_q   <= s1_sum_q;
                s2_cy_q    <= s1_cy_q;
                s2_trans_q <= tcnt;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sum   = s2_sum_q;
    assign out_cy    = s2_cy_q;
    assign out_trans = s2_trans_q;

    // ---------------- statistics ----------------
    logic [ACC_W-1:0] stat_trans_q, stat_trans_d;
    logic [ACC_W-1:0] stat_count_q, stat_count_d;
    logic             stat_sat_q, stat_sat_d;
    logic [ACC_W:0]   trans_sum, count_sum;

    always_comb begin
        // One extra bit catches the overflow that triggers clamping.
        trans_sum    = {1'b0, stat_trans_q} + (ACC_W+1)'(s2_trans_q);
        count_sum    = {1'b0, stat_count_q} + (ACC_W+1)'(1);
        stat_trans_d = stat_trans_q;
        stat_count_d = stat_count_q;
        stat_sat_d   = stat_sat_q;
        if (stat_clr && out_xfer) begin
            // Clear and delivery together: the beat starts the new window.
            stat_trans_d = ACC_W'(s2_trans_q);
            stat_count_d = ACC_W'(1);
            stat_sat_d   = 1'b0;
        end else if (stat_clr) begin
            stat_trans_d = '0;
            stat_count_d = '0;
            stat_sat_d   = 1'b0;
        end else if (out_xfer) begin
            stat_trans_d = trans_sum[ACC_W] ? ACC_MAX : trans_sum[ACC_W-1:0];
            stat_count_d = count_sum[ACC_W] ? ACC_MAX : count_sum[ACC_W-1:0];
            stat_sat_d   = stat_sat_q || trans_sum[ACC_W] || count_sum[ACC_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_trans_q <= '0;
            stat_count_q <= '0;
            stat_sat_q   <= 1'b0;
        end else begin
            stat_trans_q <= stat_trans_d;
            stat_count_q <= stat_count_d;
            stat_sat_q   <= stat_sat_d;
        end
    end

    assign stat_trans = stat_trans_q;
    assign stat_count = stat_count_q;
    assign stat_sat   = stat_sat_q;

endmodule

// File: tb/tb_add_transition_pipe.sv
module tb_add_transition_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_sub = 1'b0;
    logic        out_ready = 1'b0;
    logic        stat_clr = 1'b0;

    logic        in_ready, out_valid, out_cy, stat_sat;
    logic [31:0] out_sum, stat_trans, stat_count;
    logic [4:0]  out_trans;

    logic        b_in_ready, b_out_valid, b_out_cy, b_stat_sat;
    logic [31:0] b_out_sum;
    logic [4:0]  b_out_trans;
    logic [5:0]  b_stat_trans, b_stat_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add_transition_pipe #(.WIDTH(32), .ACC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cy(out_cy),
        .out_trans(out_trans), .stat_clr(stat_clr), .stat_trans(stat_trans),
        .stat_count(stat_count), .stat_sat(stat_sat));

    add_transition_pipe #(.WIDTH(32), .ACC_W(6)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_sum(b_out_sum), .out_cy(b_out_cy),
        .out_trans(b_out_trans), .stat_clr(stat_clr), .stat_trans(b_stat_trans),
        .stat_count(b_stat_count), .stat_sat(b_stat_sat));

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
        in_valid = v; in_a = a; in_b = b; in_sub = s;
    endtask

    task automatic test_reset;
        drive(0, 0, 0, 0);
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_sum !== 32'h0 || out_cy !== 1'b0 || out_trans !== 5'd0) begin errors++; $display("FAIL rst_out_data got %h/%b/%0d exp 0/0/0", out_sum, out_cy, out_trans); end
        checks++; if (stat_trans !== 32'd0 || stat_count !== 32'd0 || stat_sat !== 1'b0) begin errors++; $display("FAIL rst_stats got %0d/%0d/%b exp 0/0/0", stat_trans, stat_count, stat_sat); end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_add_basic;
        @(negedge clk); drive(1, 32'h1, 32'h1, 0);
        @(negedge clk); drive(0, 0, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add1_latency got out_valid %b exp 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sum !== 32'h2 || out_cy !== 1'b0 || out_trans !== 5'd2) begin errors++; $display("FAIL add1 got v%b %h cy%b t%0d exp v1 00000002 cy0 t2", out_valid, out_sum, out_cy, out_trans); end
    endtask

    task automatic test_add_edges;
        @(negedge clk); drive(1, 32'hFFFF_FFFF, 32'h1, 0);
        @(negedge clk); drive(1, 32'h5555_5554, 32'h1, 0);
        @(negedge clk); drive(0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1 || out_sum !== 32'h0 || out_cy !== 1'b1 || out_trans !== 5'd0) begin errors++; $display("FAIL add_wrap got v%b %h cy%b t%0d exp v1 00000000 cy1 t0", out_valid, out_sum, out_cy, out_trans); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sum !== 32'h5555_5555 || out_cy !== 1'b0 || out_trans !== 5'd31) begin errors++; $display("FAIL add_alt got v%b %h cy%b t%0d exp v1 55555555 cy0 t31", out_valid, out_sum, out_cy, out_trans); end
    endtask

    task automatic test_sub;
        @(negedge clk); drive(1, 32'h0, 32'h1, 1);
        @(negedge clk); drive(1, 32'h7, 32'h3, 1);
        @(negedge clk); drive(0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1 || out_sum !== 32'hFFFF_FFFF || out_cy !== 1'b1 || out_trans !== 5'd0) begin errors++; $display("FAIL sub_borrow got v%b %h cy%b t%0d exp v1 ffffffff cy1 t0", out_valid, out_sum, out_cy, out_trans); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sum !== 32'h4 || out_cy !== 1'b0 || out_trans !== 5'd2) begin errors++; $display("FAIL sub_7m3 got v%b %h cy%b t%0d exp v1 00000004 cy0 t2", out_valid, out_sum, out_cy, out_trans); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ea[4], eb[4], es[4];
        logic [4:0]  et[4];
        int sent, got, cyc;
        ea = '{32'h10, 32'h20, 32'h03, 32'hF0};
        eb = '{32'h01, 32'h20, 32'h01, 32'h0F};
        es = '{32'h11, 32'h40, 32'h02, 32'hFF};
        et = '{5'd3, 5'd2, 5'd2, 5'd1};
        sent = 0; got = 0; cyc = 0;
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            out_ready = (cyc >= 3);
            if (sent < 4) drive(1, ea[sent], eb[sent], (sent == 2));
            else          drive(0, 0, 0, 0);
            #1;
            if (cyc == 2 || cyc == 3) begin
                checks++; if (out_valid !== 1'b1 || out_sum !== 32'h11 || out_trans !== 5'd3) begin errors++; $display("FAIL b2b_hold cyc%0d got v%b %h t%0d exp v1 00000011 t3", cyc, out_valid, out_sum, out_trans); end
            end
            if (cyc == 2) begin
                checks++; if (in_ready !== 1'b0 || sent !== 2) begin errors++; $display("FAIL b2b_backpressure got in_ready %b accepted %0d exp 0 2", in_ready, sent); end
            end
            if (out_valid && out_ready) begin
                checks++; if (out_sum !== es[got] || out_cy !== 1'b0 || out_trans !== et[got]) begin errors++; $display("FAIL b2b_order beat%0d got %h cy%b t%0d exp %h cy0 t%0d", got, out_sum, out_cy, out_trans, es[got], et[got]); end
                got++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        drive(0, 0, 0, 0);
        // Released at cyc 3; four results one per cycle ends at cyc 6.
        checks++; if (got !== 4 || cyc !== 7) begin errors++; $display("FAIL b2b_throughput got %0d beats by cycle %0d exp 4 by 7", got, cyc); end
    endtask

    task automatic test_stats;
        @(negedge clk);
        checks++; if (stat_trans !== 32'd43 || stat_count !== 32'd9 || stat_sat !== 1'b0) begin errors++; $display("FAIL stat_tally got %0d/%0d/%b exp 43/9/0", stat_trans, stat_count, stat_sat); end
        stat_clr = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            stat_clr = 1'b0;
            if (k < 3)       drive(1, 32'h5555_5554, 32'h1, 0);
            else if (k == 3) drive(1, 32'h1, 32'h1, 0);
            else             drive(0, 0, 0, 0);
            #1;
            case (k)
                0: begin checks++; if (b_stat_trans !== 6'd0 || b_stat_count !== 6'd0 || b_stat_sat !== 1'b0 || stat_count !== 32'd0) begin errors++; $display("FAIL stat_clr got %0d/%0d/%b main %0d exp 0/0/0 main 0", b_stat_trans, b_stat_count, b_stat_sat, stat_count); end end
                3: begin checks++; if (b_stat_trans !== 6'd31 || b_stat_count !== 6'd1 || b_stat_sat !== 1'b0) begin errors++; $display("FAIL stat_acc1 got %0d/%0d/%b exp 31/1/0", b_stat_trans, b_stat_count, b_stat_sat); end end
                4: begin checks++; if (b_stat_trans !== 6'd62 || b_stat_count !== 6'd2 || b_stat_sat !== 1'b0) begin errors++; $display("FAIL stat_acc2 got %0d/%0d/%b exp 62/2/0", b_stat_trans, b_stat_count, b_stat_sat); end end
                5: begin
                    checks++; if (b_stat_trans !== 6'd63 || b_stat_count !== 6'd3 || b_stat_sat !== 1'b1) begin errors++; $display("FAIL stat_sat got %0d/%0d/%b exp 63/3/1", b_stat_trans, b_stat_count, b_stat_sat); end
                    checks++; if (b_out_valid !== 1'b1 || b_out_trans !== 5'd2) begin errors++; $display("FAIL stat_clr_beat got v%b t%0d exp v1 t2", b_out_valid, b_out_trans); end
                    stat_clr = 1'b1;
                end
                6: begin checks++; if (b_stat_trans !== 6'd2 || b_stat_count !== 6'd1 || b_stat_sat !== 1'b0) begin errors++; $display("FAIL stat_clr_xfer got %0d/%0d/%b exp 2/1/0", b_stat_trans, b_stat_count, b_stat_sat); end end
                default: ;
            endcase
        end
        stat_clr = 1'b0;
    endtask

    task automatic test_reset_inflight;
        @(negedge clk); out_ready = 1'b0; drive(1, 32'h1, 32'h1, 0);
        @(negedge clk); drive(1, 32'h2, 32'h2, 0);
        @(negedge clk); drive(0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_fill got v%b in_ready %b exp 1 0", out_valid, in_ready); end
        rst_n = 1'b0; #1;
        checks++; if (out_valid !== 1'b0 || out_sum !== 32'h0 || stat_count !== 32'd0 || stat_trans !== 32'd0) begin errors++; $display("FAIL rst_async got v%b %h stats %0d/%0d exp 0 0 0/0", out_valid, out_sum, stat_trans, stat_count); end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1; drive(1, 32'h7, 32'h3, 1); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
        @(negedge clk); drive(0, 0, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_latency1 got v%b exp 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sum !== 32'h4 || out_cy !== 1'b0 || out_trans !== 5'd2) begin errors++; $display("FAIL rst_latency2 got v%b %h cy%b t%0d exp v1 00000004 cy0 t2", out_valid, out_sum, out_cy, out_trans); end
    endtask

    initial begin
        test_reset;
        test_add_basic;
        test_add_edges;
        test_sub;
        test_back_to_back;
        test_stats;
        test_reset_inflight;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
